// File: rtl/pwl_bank_pkg.sv
// Purpose: shared command codes, bus width and sweep record for the PWL voice bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwl_bank_pkg;

  // Width of the command payload and readback buses.
  localparam int BUS_W  = 13;
  localparam int STEP_W = 8;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_SEL       = 3'd1,
    CMD_WR_PERIOD = 3'd2,
    CMD_WR_PHASE  = 3'd3,
    CMD_WR_SWEEP  = 3'd4,
    CMD_RD_PERIOD = 3'd5,
    CMD_RD_PHASE  = 3'd6,
    CMD_CLR_ALL   = 3'd7
  } cmd_e;

  // Per-channel sweep setting: dir=0 lengthens the period, dir=1 shortens it.
  typedef struct packed {
    logic              dir;
    logic [STEP_W-1:0] step;
  } sweep_t;

endpackage

// File: rtl/pwl_chan_update.sv
// Purpose: next-state of one channel (counter reload, phase step, sweep saturation).
// Latency: purely combinational; the caller time-shares it across channels.
// Backpressure: none.
//
// Ports: period/counter/phase/sweep = current channel state;
//        nxt_period/nxt_counter/nxt_phase = state after one scheduler visit.
// A step of 0 disables sweep, so the bank ties sweep to 0 when PWL_SWEEP_EN
// is undefined and the period path folds away.
module pwl_chan_update
  import pwl_bank_pkg::*;
#(
  parameter int PERIOD_W = 13,
  parameter int PHASE_W  = 12
) (
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] counter,
  input  logic [PHASE_W-1:0]  phase,
  input  sweep_t              sweep,
  output logic [PERIOD_W-1:0] nxt_period,
  output logic [PERIOD_W-1:0] nxt_counter,
  output logic [PHASE_W-1:0]  nxt_phase
);

  localparam int SUM_W = PERIOD_W + 1;

  logic [SUM_W-1:0]    sum;
  logic [PERIOD_W-1:0] step_ext;

  always_comb begin
    nxt_period  = period;
    nxt_counter = counter;
    nxt_phase   = phase;
    step_ext    = PERIOD_W'(sweep.step);
    sum         = SUM_W'(period) + SUM_W'(sweep.step);

    if (period == '0) begin
      // halted channel: nothing moves
    end else if (counter != '0) begin
      nxt_counter = counter - PERIOD_W'(1);
    end else begin
      nxt_counter = period;
      nxt_phase   = phase + PHASE_W'(1);
      // Sweep only acts on the all-ones -> 0 phase wrap; the reload above
      // still uses the old period, the new one applies from the next reload.
      if ((&phase) && (sweep.step != '0)) begin
        if (!sweep.dir) begin
          nxt_period = sum[PERIOD_W] ? '1 : sum[PERIOD_W-1:0];
        end else begin
          nxt_period = (period <= step_ext) ? PERIOD_W'(1) : (period - step_ext);
        end
      end
    end
  end

endmodule

// File: rtl/pwl_voice_bank.sv
// Purpose: NUM_CH-channel phase generator, round-robin updated, command-programmed.
// Latency: sample 1 cycle after its scheduler slot; readback data 1 cycle after accept.
// Backpressure: cmd_ready drops during the readback cycle; sample stream cannot stall.
//
// Ports: clk, rst_n (async, active-low); cmd_valid/cmd/wdata/cmd_ready command
//        channel; data_ready/data_out readback; sample_valid/sample_ch/sample_phase
//        stream. Optional per-channel period sweep on phase wrap: PWL_SWEEP_EN.
module pwl_voice_bank
  import pwl_bank_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int PERIOD_W = 13,
  parameter  int PHASE_W  = 12,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd,
  input  logic [BUS_W-1:0]   wdata,
  output logic               cmd_ready,
  output logic               data_ready,
  output logic [BUS_W-1:0]   data_out,
  output logic               sample_valid,
  output logic [CH_W-1:0]    sample_ch,
  output logic [PHASE_W-1:0] sample_phase
);

  logic [CH_W-1:0]     cur_ch;
  logic [CH_W-1:0]     sch;
  // Set on the first edge after reset; the scheduler starts on the second.
  logic                run;

  logic [PERIOD_W-1:0] period_q  [NUM_CH];
  logic [PERIOD_W-1:0] counter_q [NUM_CH];
  logic [PHASE_W-1:0]  phase_q   [NUM_CH];
`ifdef PWL_SWEEP_EN
  sweep_t              sweep_q   [NUM_CH];
`endif

  cmd_e                cmd_c;
  logic                cmd_acc;
  logic                wr_ch;
  logic                is_clr;
  logic                drop_upd;
  logic                rd_acc;
  logic [BUS_W-1:0]    rd_dat;
  sweep_t              sch_sweep;
  logic [PERIOD_W-1:0] upd_period;
  logic [PERIOD_W-1:0] upd_counter;
  logic [PHASE_W-1:0]  upd_phase;
  logic [PHASE_W-1:0]  samp_phase_nxt;

  assign cmd_c     = cmd_e'(cmd);
  assign cmd_ready = run & ~data_ready;
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign is_clr    = cmd_acc && (cmd_c == CMD_CLR_ALL);
  assign rd_acc    = cmd_acc && ((cmd_c == CMD_RD_PERIOD) || (cmd_c == CMD_RD_PHASE));

`ifdef PWL_SWEEP_EN
  assign wr_ch     = cmd_acc && ((cmd_c == CMD_WR_PERIOD) || (cmd_c == CMD_WR_PHASE) ||
                                 (cmd_c == CMD_WR_SWEEP));
  assign sch_sweep = sweep_q[sch];
`else
  assign wr_ch     = cmd_acc && ((cmd_c == CMD_WR_PERIOD) || (cmd_c == CMD_WR_PHASE));
  assign sch_sweep = '0;
`endif

  // A command touching the scheduled channel (or clearing everything) owns
  // that channel's state this cycle; the scheduled update is discarded.
  assign drop_upd = (wr_ch && (cur_ch == sch)) || is_clr;

  pwl_chan_update #(
    .PERIOD_W (PERIOD_W),
    .PHASE_W  (PHASE_W)
  ) u_chan_update (
    .period      (period_q[sch]),
    .counter     (counter_q[sch]),
    .phase       (phase_q[sch]),
    .sweep       (sch_sweep),
    .nxt_period  (upd_period),
    .nxt_counter (upd_counter),
    .nxt_phase   (upd_phase)
  );

  always_comb begin
    rd_dat = '0;
    if (cmd_c == CMD_RD_PERIOD) rd_dat = BUS_W'(period_q[cur_ch]);
    if (cmd_c == CMD_RD_PHASE)  rd_dat = BUS_W'(phase_q[cur_ch]);
  end

  // Phase of the scheduled channel as it will be after this edge.
  always_comb begin
    samp_phase_nxt = upd_phase;
    if (is_clr) begin
      samp_phase_nxt = '0;
    end else if (cmd_acc && (cmd_c == CMD_WR_PHASE) && (cur_ch == sch)) begin
      samp_phase_nxt = wdata[PHASE_W-1:0];
    end else if (drop_upd) begin
      samp_phase_nxt = phase_q[sch];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i]  <= '0;
        counter_q[i] <= '0;
        phase_q[i]   <= '0;
`ifdef PWL_SWEEP_EN
        sweep_q[i]   <= '0;
`endif
      end
      cur_ch       <= '0;
      sch          <= '0;
      run          <= 1'b0;
      data_ready   <= 1'b0;
      data_out     <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_phase <= '0;
    end else begin
      run        <= 1'b1;
      data_ready <= rd_acc;
      data_out   <= rd_acc ? rd_dat : '0;

      if (run) begin
        sch          <= sch + CH_W'(1);
        sample_valid <= 1'b1;
        sample_ch    <= sch;
        sample_phase <= samp_phase_nxt;
        if (!drop_upd) begin
          period_q[sch]  <= upd_period;
          counter_q[sch] <= upd_counter;
          phase_q[sch]   <= upd_phase;
        end
      end

      if (cmd_acc) begin
        case (cmd_c)
          CMD_SEL: cur_ch <= wdata[CH_W-1:0];
          CMD_WR_PERIOD: begin
            period_q[cur_ch]  <= wdata[PERIOD_W-1:0];
            counter_q[cur_ch] <= wdata[PERIOD_W-1:0];
          end
          CMD_WR_PHASE: phase_q[cur_ch] <= wdata[PHASE_W-1:0];
`ifdef PWL_SWEEP_EN
          CMD_WR_SWEEP: sweep_q[cur_ch] <= '{dir: wdata[12], step: wdata[STEP_W-1:0]};
`endif
          CMD_CLR_ALL: begin
            for (int i = 0; i < NUM_CH; i++) begin
              phase_q[i]   <= '0;
              counter_q[i] <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
